// File: rtl/seg_scan_ctrl.sv
// Digit-scan controller for a 6-digit multiplexed 7-segment display.
// Optional display blinking is built only when SEG_BLINK_EN is defined.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLINK_FRM = 83
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] number_in,
  input  logic        number_vld,
  input  logic        blink,
  output logic [5:0]  sel,
  output logic [19:0] number,
  output logic        frame_done
);

  localparam int              DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [19:0]     SAT_MAX   = 20'd999_999;
  localparam logic [5:0]      SEL_UNITS = 6'b011111;
  localparam logic [5:0]      SEL_LAST  = 6'b111110;

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [5:0]       scan_q, scan_d;
  logic [19:0]      number_q, number_d;
  logic [19:0]      pending_q, pending_d;
  logic             pendFlag_q, pendFlag_d;
  logic             frameDone_q;
  logic             tick;
  logic             wrap;
  logic [19:0]      numSat;

  always_comb begin
    numSat     = (number_in > SAT_MAX) ? SAT_MAX : number_in;
    tick       = (divCnt_q == DIV_LAST);
    wrap       = tick && (scan_q == SEL_LAST);
    divCnt_d   = tick ? '0 : divCnt_q + 1'b1;
    scan_d     = scan_q;
    number_d   = number_q;
    pending_d  = pending_q;
    pendFlag_d = pendFlag_q;

    if (tick) begin
      scan_d = wrap ? SEL_UNITS : {1'b1, scan_q[5:1]};
    end

    if (number_vld) begin
      pending_d  = numSat;
      pendFlag_d = 1'b1;
    end

    // A strobe landing on the wrap cycle goes straight to the display and
    // supersedes whatever was pending for this frame.
    if (wrap) begin
      pendFlag_d = 1'b0;
      if (number_vld) begin
        number_d = numSat;
      end else if (pendFlag_q) begin
        number_d = pending_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt_q    <= '0;
      scan_q      <= SEL_UNITS;
      number_q    <= '0;
      pending_q   <= '0;
      pendFlag_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      divCnt_q    <= divCnt_d;
      scan_q      <= scan_d;
      number_q    <= number_d;
      pending_q   <= pending_d;
      pendFlag_q  <= pendFlag_d;
      frameDone_q <= wrap;
    end
  end

  assign number     = number_q;
  assign frame_done = frameDone_q;

`ifdef SEG_BLINK_EN
  localparam int               FRM_W    = $clog2(BLINK_FRM + 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRM - 1);

  logic [FRM_W-1:0] frmCnt_q, frmCnt_d;
  logic             phaseOn_q, phaseOn_d;

  always_comb begin
    frmCnt_d  = frmCnt_q;
    phaseOn_d = phaseOn_q;
    if (!blink) begin
      frmCnt_d  = '0;
      phaseOn_d = 1'b1;
    end else if (wrap) begin
      if (frmCnt_q == FRM_LAST) begin
        frmCnt_d  = '0;
        phaseOn_d = ~phaseOn_q;
      end else begin
        frmCnt_d = frmCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frmCnt_q  <= '0;
      phaseOn_q <= 1'b1;
    end else begin
      frmCnt_q  <= frmCnt_d;
      phaseOn_q <= phaseOn_d;
    end
  end

  // Only the visible select is blanked; the rotation keeps running underneath.
  assign sel = (blink && !phaseOn_q) ? 6'b111111 : scan_q;
`else
  logic unused_cfg;
  assign unused_cfg = blink & (BLINK_FRM >= 1);
  assign sel        = scan_q;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_FRM=2.
// Blink checks are compiled in only when SEG_BLINK_EN is defined.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_FRM = 2;
  localparam int FRAME     = 6 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] number_in;
  logic        number_vld;
  logic        blink;
  logic [5:0]  sel;
  logic [19:0] number;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  int          k;
  bit          chkEn = 1'b0;
  bit          blinkFromReset = 1'b0;
  logic [19:0] shown;
  logic [19:0] expQ[$];

  typedef struct {
    logic [19:0] valA;
    bit          vldA;
    int          offA;
    logic [19:0] valB;
    bit          vldB;
    int          offB;
    logic [19:0] expNum;
  } vec_t;

  vec_t tbl[11];

  seg_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_FRM(BLINK_FRM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .number_in (number_in),
    .number_vld(number_vld),
    .blink     (blink),
    .sel       (sel),
    .number    (number),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release; the expected scan position derives from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h (k=%0d)", name, act, exp, k);
    end
  endtask

  function automatic vec_t mkVec(input logic [19:0] valA, input bit vldA, input int offA,
                                 input logic [19:0] valB, input bit vldB, input int offB,
                                 input logic [19:0] expNum);
    vec_t v;
    v.valA = valA; v.vldA = vldA; v.offA = offA;
    v.valB = valB; v.vldB = vldB; v.offB = offB;
    v.expNum = expNum;
    return v;
  endfunction

  // Scan position and frame pulse, expected from elapsed cycles alone.
  always @(negedge clk) begin
    if (chkEn && rst_n) begin
      int         idx;
      logic [5:0] expSel;
      logic [5:0] oneHot;
      idx    = (k / SCAN_DIV) % 6;
      oneHot = 6'b100000 >> idx;
      expSel = ~oneHot;
`ifdef SEG_BLINK_EN
      if (blink && blinkFromReset && (((k / FRAME) / BLINK_FRM) % 2 == 1)) expSel = 6'b111111;
`endif
      checkOutput("sel", {14'd0, sel}, {14'd0, expSel});
      checkOutput("frame_done", {19'd0, frame_done}, {19'd0, (k > 0) && (k % FRAME == 0)});
    end
  end

  // Runs one whole frame starting at a frame boundary sample point.
  task automatic applyStimulus(input vec_t v, input string name);
    logic [19:0] e;
    expQ.push_back(v.expNum);
    for (int o = 0; o < FRAME; o++) begin
      checkOutput({name, " hold"}, number, shown);
      number_vld = 1'b0;
      number_in  = 20'd0;
      if (v.vldA && o == v.offA) begin number_in = v.valA; number_vld = 1'b1; end
      if (v.vldB && o == v.offB) begin number_in = v.valB; number_vld = 1'b1; end
      @(negedge clk);
    end
    number_vld = 1'b0;
    number_in  = 20'd0;
    checkOutput({name, " pulse"}, {19'd0, frame_done}, 20'd1);
    if (expQ.size() == 0) begin
      checkOutput({name, " queue"}, 20'd0, 20'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({name, " apply"}, number, e);
      shown = e;
    end
  endtask

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = mkVec(20'd0,       0, 0,  20'd0, 0, 0,  20'd0);
    tbl[1]  = mkVec(20'd37,      1, 5,  20'd0, 0, 0,  20'd37);
    tbl[2]  = mkVec(20'd12,      1, 3,  20'd58, 1, 15, 20'd58);
    tbl[3]  = mkVec(20'hFFFFF,   1, 10, 20'd0, 0, 0,  20'd999_999);
    tbl[4]  = mkVec(20'hFFFFF,   1, 2,  20'd5, 1, 23, 20'd5);
    tbl[5]  = mkVec(20'd0,       0, 0,  20'd0, 0, 0,  20'd5);
    tbl[6]  = mkVec(20'd1_000_000, 1, 8, 20'd0, 0, 0, 20'd999_999);
    tbl[7]  = mkVec(20'd999_998, 1, 1,  20'd0, 0, 0,  20'd999_998);
    tbl[8]  = mkVec(20'd999_999, 1, 22, 20'd0, 0, 0,  20'd999_999);
    tbl[9]  = mkVec(20'd0,       1, 0,  20'd0, 0, 0,  20'd0);
    tbl[10] = mkVec(20'd123_456, 1, 23, 20'd0, 0, 0,  20'd123_456);

    rst_n      = 1'b0;
    number_in  = 20'd0;
    number_vld = 1'b0;
    blink      = 1'b0;
    shown      = 20'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset sel", {14'd0, sel}, {14'd0, 6'b011111});
    checkOutput("reset number", number, 20'd0);
    checkOutput("reset frame_done", {19'd0, frame_done}, 20'd0);

`ifndef SEG_BLINK_EN
    blink = 1'b1;
`endif
    rst_n = 1'b1;
    chkEn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // Pending 42 is discarded by a reset in the hundreds slot.
    for (int o = 0; o < 10; o++) begin
      number_vld = (o == 2);
      number_in  = (o == 2) ? 20'd42 : 20'd0;
      @(negedge clk);
    end
    number_vld = 1'b0;
    number_in  = 20'd0;
    checkOutput("pre-reset sel", {14'd0, sel}, {14'd0, 6'b110111});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset sel", {14'd0, sel}, {14'd0, 6'b011111});
    checkOutput("midreset number", number, 20'd0);
    checkOutput("midreset frame_done", {19'd0, frame_done}, 20'd0);
    @(negedge clk);
    rst_n = 1'b1;
    shown = 20'd0;
    applyStimulus(mkVec(20'd0, 0, 0, 20'd0, 0, 0, 20'd0), "postreset");
    applyStimulus(mkVec(20'd77, 1, 11, 20'd0, 0, 0, 20'd77), "postreset2");

`ifdef SEG_BLINK_EN
    rst_n = 1'b0;
    blink = 1'b1;
    blinkFromReset = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    shown = 20'd0;
    applyStimulus(mkVec(20'd0, 0, 0, 20'd0, 0, 0, 20'd0), "blink0");
    applyStimulus(mkVec(20'd0, 0, 0, 20'd0, 0, 0, 20'd0), "blink1");
    checkOutput("blink dark sel", {14'd0, sel}, {14'd0, 6'b111111});
    applyStimulus(mkVec(20'd7, 1, 4, 20'd0, 0, 0, 20'd7), "blink2");
    applyStimulus(mkVec(20'd0, 0, 0, 20'd0, 0, 0, 20'd7), "blink3");
    checkOutput("blink lit sel", {14'd0, sel}, {14'd0, 6'b011111});
    applyStimulus(mkVec(20'd0, 0, 0, 20'd0, 0, 0, 20'd7), "blink4");
    applyStimulus(mkVec(20'd0, 0, 0, 20'd0, 0, 0, 20'd7), "blink5");
`endif

    chkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
